// File: rtl/stack_pkg.sv
// Shared types and op classification helpers for the parametrised operand stack.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_PUSH        = 3'd1,
        OP_POP         = 3'd2,
        OP_REPLACE     = 3'd3,
        OP_POP_REPLACE = 3'd4,
        OP_DUP         = 3'd5,
        OP_SWAP        = 3'd6,
        OP_OVER        = 3'd7
    } stk_op_e;

    function automatic logic [1:0] stk_min_count(stk_op_e op);
        case (op)
            OP_POP, OP_REPLACE, OP_DUP:          return 2'd1;
            OP_POP_REPLACE, OP_SWAP, OP_OVER:    return 2'd2;
            default:                             return 2'd0;
        endcase
    endfunction

    function automatic logic stk_grows(stk_op_e op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_guard.sv
// Combinational legality check: classifies the requested op against the current occupancy.
module stack_guard
    import stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  stk_op_e         op,
    input  logic [CW-1:0]   count,
    output logic            legal,
    output logic            ovf,
    output logic            unf
);

    // Underflow is tested first so an op can never flag both at once.
    assign unf   = (CW'(stk_min_count(op)) > count);
    assign ovf   = !unf && stk_grows(op) && (count == CW'(DEPTH));
    assign legal = !unf && !ovf;

endmodule

// File: rtl/param_reg_stack.sv
// Register-array operand stack addressed by count; entries never shift, only the pointer moves.
module param_reg_stack
    import stack_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clr,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    stk_op_e          op_e;
    logic             legal;
    logic             ovf;
    logic             unf;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    sec_idx;
    logic [PW-1:0]    push_idx;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic             wr0_en;
    logic [PW-1:0]    wr0_idx;
    logic [WIDTH-1:0] wr0_data;
    logic             wr1_en;
    logic [PW-1:0]    wr1_idx;
    logic [WIDTH-1:0] wr1_data;
    logic [CW-1:0]    count_next;

    assign op_e     = stk_op_e'(op);
    assign top_idx  = PW'(count - CW'(1));
    assign sec_idx  = PW'(count - CW'(2));
    assign push_idx = PW'(count);
    assign a_raw    = mem[top_idx];
    assign b_raw    = mem[sec_idx];

    assign a     = (count != '0)      ? a_raw : '0;
    assign b     = (count >= CW'(2))  ? b_raw : '0;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    stack_guard #(.DEPTH(DEPTH), .CW(CW)) u_guard (
        .op    (op_e),
        .count (count),
        .legal (legal),
        .ovf   (ovf),
        .unf   (unf)
    );

    // Second write port exists only for SWAP, which rewrites top and second together.
    always_comb begin
        wr0_en     = 1'b0;
        wr0_idx    = top_idx;
        wr0_data   = w;
        wr1_en     = 1'b0;
        wr1_idx    = sec_idx;
        wr1_data   = a_raw;
        count_next = count;
        if (legal) begin
            unique case (op_e)
                OP_PUSH: begin
                    wr0_en     = 1'b1;
                    wr0_idx    = push_idx;
                    count_next = count + CW'(1);
                end
                OP_POP: count_next = count - CW'(1);
                OP_REPLACE: wr0_en = 1'b1;
                OP_POP_REPLACE: begin
                    wr0_en     = 1'b1;
                    wr0_idx    = sec_idx;
                    count_next = count - CW'(1);
                end
                OP_DUP: begin
                    wr0_en     = 1'b1;
                    wr0_idx    = push_idx;
                    wr0_data   = a_raw;
                    count_next = count + CW'(1);
                end
                OP_SWAP: begin
                    wr0_en   = 1'b1;
                    wr0_data = b_raw;
                    wr1_en   = 1'b1;
                end
                OP_OVER: begin
                    wr0_en     = 1'b1;
                    wr0_idx    = push_idx;
                    wr0_data   = b_raw;
                    count_next = count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (wr0_en) mem[wr0_idx] <= wr0_data;
            if (wr1_en) mem[wr1_idx] <= wr1_data;
            count <= count_next;
            if (ovf) err_ovf <= 1'b1;
            if (unf) err_unf <= 1'b1;
        end
    end

endmodule

// File: doc/param_reg_stack.md
# param_reg_stack

Parametrised operand stack for the stack processor datapath. It generalises the fixed 16-bit data stack with configurable width and depth, an occupancy count, full/empty status, and sticky overflow/underflow error flags. Illegal operations are blocked rather than corrupting state. It sits between the stack-control mux (new top-of-stack value) and the ALU/branch logic, which read the top two entries.

## Interface
- `WIDTH`, default 16: data width of each entry.
- `DEPTH`, default 16: number of entries; must be ≥ 2.
- `CW`, default $clog2(DEPTH+1): width of `count` (derived, not overridden).

Ports:
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous flush: empties the stack and clears both error flags.
- `op`  in  3  stack operation for this cycle (`stk_op_e`).
- `w`  in  WIDTH  write data for PUSH, REPLACE and POP_REPLACE.
- `a`  out  WIDTH  top of stack; 0 when `count`=0.
- `b`  out  WIDTH  second of stack; 0 when `count`<2.
- `count`  out  CW  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count`==0.
- `full`  out  1  `count`==DEPTH.
- `err_ovf`  out  1  sticky: an op was blocked by overflow.
- `err_unf`  out  1  sticky: an op was blocked by underflow.

## Operation
- Op encoding:
  - 0 NOP
  - 1 PUSH: new top=`w`, count+1.
  - 2 POP: count−1.
  - 3 REPLACE: top=`w`, count unchanged.
  - 4 POP_REPLACE: drop top two, push `w`, count−1 (binary ALU result).
  - 5 DUP: push copy of `a`, count+1.
  - 6 SWAP: exchange `a` and `b`.
  - 7 OVER: push copy of `b`, count+1.
- Minimum count required per op:
  - PUSH 0
  - POP, REPLACE, DUP: 1
  - POP_REPLACE, SWAP, OVER: 2
- Underflow: count is below the minimum for the op. The op is blocked, with no state change, and `err_unf` is set.
- Overflow: PUSH, DUP or OVER while `full`. The op is blocked and `err_ovf` is set.
- Error flags stay set until `reset` or `clr`. A set flag does not stop later legal ops from executing.
- Entries below the second-of-stack position are never modified except by pushes over them.
- `a` and `b` are combinational reads of the storage selected by `count`, gated to 0 when they are invalid.

## Timing
- Single-cycle ops. `op` and `w` are sampled at a rising edge, and the results are visible on `a`/`b`/`count`/flags right after that edge. One op per cycle, back-to-back with no bubble.
- Priority: `reset` (async) > `clr` > `op`. When `clr` is asserted the same cycle's `op` is ignored and flags no error.
- Reset values: `count`=0, `a`=0, `b`=0, `empty`=1, `full`=0, `err_ovf`=0, `err_unf`=0. Storage is zeroed.
- Reset asserted mid-sequence takes effect immediately, without waiting for `CLK`. The first op after deassertion executes on the first rising edge.
- A blocked op and the flag set happen on the same edge. The flag is visible after that edge.
- `count` saturates at DEPTH and never wraps to 0, because overflow is blocked. It never goes negative, because underflow is blocked.

## Structure
- Package `stack_pkg` holds:
  - `stk_op_e` (3-bit enum, encoding above);
  - the function `stk_min_count(op)`;
  - the function `stk_grows(op)` (PUSH/DUP/OVER).
- Storage is an array of DEPTH registers indexed by a top pointer, which is `count`−1. There is no physical shifting of entries.
- One natural sub-module, `stack_guard`. It is combinational: it takes `op`, `count` and DEPTH, and produces `legal`, `ovf` and `unf`. The top level then gates the write enables and the flag sets with these signals.

## Test plan
All scenarios run with DEPTH=4 and WIDTH=16.
- **Reset/basic:** assert `reset`, then PUSH 0x1111 and PUSH 0x2222 → `a`=0x2222, `b`=0x1111, `count`=2; POP → `a`=0x1111, `b`=0, `count`=1.
- **Overflow:** PUSH 1,2,3,4 → `full`=1. PUSH 5 → `a`=4, `count`=4, `err_ovf`=1. DUP and OVER are also blocked. Then POP → `count`=3, `a`=3, and `err_ovf` is still 1.
- **Underflow:** from empty, POP → `err_unf`=1, `count`=0. PUSH 7 then SWAP → blocked, `a`=7, `err_unf` still 1. `clr` → both flags 0, `count`=0.
- **Stack ops:** PUSH 0xA, PUSH 0xB:
  - SWAP → `a`=0xA, `b`=0xB;
  - OVER → `a`=0xB, `count`=3;
  - DUP → `a`=0xB, `count`=4;
  - POP_REPLACE with `w`=0x16 → `a`=0x16, `b`=0xA, `count`=3;
  - REPLACE with `w`=0x5 → `a`=0x5, `count`=3.
- **Priority/async:** assert `clr` together with PUSH → `count`=0 and no flags. Assert `reset` between clock edges while `count`=3 → `count`=0 and `a`=0 before the next `CLK` edge.
- **Random:** a random op stream checked against a queue-based reference model, with `a`, `b`, `count` and flags compared every cycle. Run with DEPTH=2 and DEPTH=16.
